hpi_target: RTL and testbench



---
 rtl/hpi_if.sv | 37 +++
 rtl/hpi_target.sv | 196 +++++++++++++++++++
 tb/tb_hpi_target.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_if.sv
// ---------------------------------------------------------------------------
// hpi_if -- control side of the 16-bit, 4-register host-port interface.
//
// Signals:
//   OTG_ADDR [1:0]  register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
//   OTG_CS_N        chip select, active-low
//   OTG_RD_N        read strobe, active-low
//   OTG_WR_N        write strobe, active-low
//   OTG_INT         responder interrupt, high while the outbound mailbox is full
//
// The bidirectional data bus OTG_DATA is carried as a plain inout port next to
// this interface so the tristate net stays visible at the top of each module.
// Modports: master (host side) and slave (responder side).
// ---------------------------------------------------------------------------
interface hpi_if;
    logic [1:0] OTG_ADDR;
    logic       OTG_CS_N;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_INT;

    modport master (
        output OTG_ADDR,
        output OTG_CS_N,
        output OTG_RD_N,
        output OTG_WR_N,
        input  OTG_INT
    );

    modport slave (
        input  OTG_ADDR,
        input  OTG_CS_N,
        input  OTG_RD_N,
        input  OTG_WR_N,
        output OTG_INT
    );
endinterface

// File: rtl/hpi_target.sv
// ---------------------------------------------------------------------------
// hpi_target -- HPI responder standing in for the USB OTG controller.
//
// Host side: word-addressed shared memory behind an auto-incrementing byte
// address pointer, a bidirectional mailbox and a STATUS register
// {overrun, outbound full, inbound valid}.
// Local side: reads the inbound mailbox, writes the outbound mailbox and
// reads the shared memory through a registered port.
//
// Ports:
//   Clk, Reset        system clock, synchronous active-high reset
//   OTG_RST_N         host reset, active-low, sampled synchronously
//   hpi (slave)       OTG_ADDR / OTG_CS_N / OTG_RD_N / OTG_WR_N / OTG_INT
//   OTG_DATA          16-bit bidirectional data bus
//   lcl_mbx_rdata     last word the host wrote to MAILBOX
//   lcl_mbx_valid     inbound mailbox holds unread data (STATUS[0])
//   lcl_mbx_ack       local consume pulse, clears lcl_mbx_valid
//   lcl_mbx_wr/wdata  local write of the outbound mailbox
//   lcl_mem_addr      local memory word address
//   lcl_mem_rdata     local memory read data, 1-cycle latency
// ---------------------------------------------------------------------------
module hpi_target #(
    parameter int MEM_AW = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              OTG_RST_N,
    hpi_if.slave              hpi,
    inout  wire  [15:0]       OTG_DATA,
    output logic [15:0]       lcl_mbx_rdata,
    output logic              lcl_mbx_valid,
    input  logic              lcl_mbx_ack,
    input  logic              lcl_mbx_wr,
    input  logic [15:0]       lcl_mbx_wdata,
    input  logic [MEM_AW-1:0] lcl_mem_addr,
    output logic [15:0]       lcl_mem_rdata
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MBX  = 2'd1;
    localparam logic [1:0] REG_ADDR = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic {BUS_IDLE, BUS_DRIVE} bus_state_t;

    logic              srst;
    logic              wr_act, rd_act;
    logic              wr_act_q_reg, rd_act_q_reg;
    logic              wr_start, rd_start;
    logic              wr_mem, wr_mbx, wr_addr;
    logic              rd_mem, rd_mbx, rd_stat;
    logic [15:0]       addr_reg;
    logic [15:0]       rd_data_reg;
    logic [15:0]       mbx_in_reg, mbx_out_reg;
    logic              st_valid_reg, st_full_reg, st_ovr_reg;
    logic [MEM_AW-1:0] mem_idx;
    logic [15:0]       mem [0:DEPTH-1];
    bus_state_t        bus_state_reg, bus_state_next;

    // Either reset source clears the whole responder (memory excepted).
    assign srst = Reset | ~OTG_RST_N;

    // A write wins when both strobes are low.
    assign wr_act   = ~hpi.OTG_CS_N & ~hpi.OTG_WR_N;
    assign rd_act   = ~hpi.OTG_CS_N & ~hpi.OTG_RD_N & hpi.OTG_WR_N;
    assign wr_start = wr_act & ~wr_act_q_reg;
    assign rd_start = rd_act & ~rd_act_q_reg;

    assign wr_mem   = wr_start && (hpi.OTG_ADDR == REG_DATA);
    assign wr_mbx   = wr_start && (hpi.OTG_ADDR == REG_MBX);
    assign wr_addr  = wr_start && (hpi.OTG_ADDR == REG_ADDR);
    assign rd_mem   = rd_start && (hpi.OTG_ADDR == REG_DATA);
    assign rd_mbx   = rd_start && (hpi.OTG_ADDR == REG_MBX);
    assign rd_stat  = rd_start && (hpi.OTG_ADDR == REG_STAT);

    // Byte address: bit 0 is dropped and bits above MEM_AW alias.
    assign mem_idx  = addr_reg[MEM_AW:1];

    // Strobe history; cleared on reset so a strobe held across reset
    // produces a fresh start afterwards.
    always_ff @(posedge Clk) begin
        if (srst) begin
            wr_act_q_reg <= 1'b0;
            rd_act_q_reg <= 1'b0;
        end else begin
            wr_act_q_reg <= wr_act;
            rd_act_q_reg <= rd_act;
        end
    end

    // Address pointer, 16-bit wrap on increment.
    always_ff @(posedge Clk) begin
        if (srst) begin
            addr_reg <= 16'h0000;
        end else if (wr_addr) begin
            addr_reg <= OTG_DATA;
        end else if (wr_mem || rd_mem) begin
            addr_reg <= addr_reg + 16'd2;
        end
    end

    // Shared memory: host write port, no reset on contents.
    always_ff @(posedge Clk) begin
        if (wr_mem) begin
            mem[mem_idx] <= OTG_DATA;
        end
    end

    // Local registered read; a same-cycle host write returns old data.
    always_ff @(posedge Clk) begin
        if (srst) begin
            lcl_mem_rdata <= 16'h0000;
        end else begin
            lcl_mem_rdata <= mem[lcl_mem_addr];
        end
    end

    // Host read data, captured once per access on the start cycle.
    always_ff @(posedge Clk) begin
        if (srst) begin
            rd_data_reg <= 16'h0000;
        end else if (rd_start) begin
            case (hpi.OTG_ADDR)
                REG_DATA: rd_data_reg <= mem[mem_idx];
                REG_MBX:  rd_data_reg <= mbx_out_reg;
                REG_ADDR: rd_data_reg <= addr_reg;
                default:  rd_data_reg <= {13'b0, st_ovr_reg, st_full_reg, st_valid_reg};
            endcase
        end
    end

    // Inbound mailbox (host -> local). A host write beats a same-cycle ack.
    // Host write and STATUS read cannot start in the same cycle.
    always_ff @(posedge Clk) begin
        if (srst) begin
            mbx_in_reg   <= 16'h0000;
            st_valid_reg <= 1'b0;
            st_ovr_reg   <= 1'b0;
        end else if (wr_mbx) begin
            mbx_in_reg   <= OTG_DATA;
            st_valid_reg <= 1'b1;
            if (st_valid_reg) begin
                st_ovr_reg <= 1'b1;
            end
        end else begin
            if (lcl_mbx_ack) begin
                st_valid_reg <= 1'b0;
            end
            if (rd_stat) begin
                st_ovr_reg <= 1'b0;
            end
        end
    end

    // Outbound mailbox (local -> host). A local write beats a same-cycle
    // host read: the host still gets the old word (read above samples the
    // current register) and the full flag stays set.
    always_ff @(posedge Clk) begin
        if (srst) begin
            mbx_out_reg <= 16'h0000;
            st_full_reg <= 1'b0;
        end else if (lcl_mbx_wr) begin
            mbx_out_reg <= lcl_mbx_wdata;
            st_full_reg <= 1'b1;
        end else if (rd_mbx) begin
            st_full_reg <= 1'b0;
        end
    end

    // Bus drive FSM: drive from the cycle after rd_start until the cycle
    // after the read strobe is released.
    always_ff @(posedge Clk) begin
        if (srst) begin
            bus_state_reg <= BUS_IDLE;
        end else begin
            bus_state_reg <= bus_state_next;
        end
    end

    always_comb begin
        bus_state_next = bus_state_reg;
        case (bus_state_reg)
            BUS_IDLE:  if (rd_start) bus_state_next = BUS_DRIVE;
            BUS_DRIVE: if (!rd_act)  bus_state_next = BUS_IDLE;
            default:   bus_state_next = BUS_IDLE;
        endcase
    end

    // The wr_act gate keeps the bus released the moment a write begins.
    assign OTG_DATA      = (bus_state_reg == BUS_DRIVE && !wr_act) ? rd_data_reg : 16'hzzzz;
    assign hpi.OTG_INT   = st_full_reg;
    assign lcl_mbx_rdata = mbx_in_reg;
    assign lcl_mbx_valid = st_valid_reg;

endmodule

// File: tb/tb_hpi_target.sv
// ---------------------------------------------------------------------------
// tb_hpi_target -- self-checking bench for hpi_target.
// The data bus carries a pullup, so a released bus reads as 0xFFFF; test
// data avoids that value.
// ---------------------------------------------------------------------------
module tb_hpi_target;
    localparam int MEM_AW = 12;
    localparam logic [15:0] REL = 16'hFFFF;

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [15:0] d;      // write data, or expected read data
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, otg_rst_n;
    logic              tb_drv_en;
    logic [15:0]       tb_drv;
    wire  [15:0]       otg_data;
    logic [15:0]       lcl_mbx_rdata, lcl_mbx_wdata, lcl_mem_rdata;
    logic              lcl_mbx_valid, lcl_mbx_ack, lcl_mbx_wr;
    logic [MEM_AW-1:0] lcl_mem_addr;

    assign otg_data = tb_drv_en ? tb_drv : 16'hzzzz;
    pullup (otg_data);

    hpi_if hpi ();

    hpi_target #(.MEM_AW(MEM_AW)) dut (
        .Clk           (clk),
        .Reset         (reset),
        .OTG_RST_N     (otg_rst_n),
        .hpi           (hpi),
        .OTG_DATA      (otg_data),
        .lcl_mbx_rdata (lcl_mbx_rdata),
        .lcl_mbx_valid (lcl_mbx_valid),
        .lcl_mbx_ack   (lcl_mbx_ack),
        .lcl_mbx_wr    (lcl_mbx_wr),
        .lcl_mbx_wdata (lcl_mbx_wdata),
        .lcl_mem_addr  (lcl_mem_addr),
        .lcl_mem_rdata (lcl_mem_rdata)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    vec_t        tbl   [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [15:0] d, input int hold);
        @(posedge clk); #1;
        hpi.OTG_ADDR = a; hpi.OTG_CS_N = 1'b0; hpi.OTG_WR_N = 1'b0;
        tb_drv = d; tb_drv_en = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        hpi.OTG_CS_N = 1'b1; hpi.OTG_WR_N = 1'b1; tb_drv_en = 1'b0;
        $display("host wr reg=%0d data=0x%04h hold=%0d", a, d, hold);
    endtask

    // Expected value goes into the scoreboard at issue and is popped when
    // the bus is sampled; drive/hold/release timing is checked as well.
    task automatic host_read(input logic [1:0] a, input logic [15:0] exp, input int hold);
        logic [15:0] got, want;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        hpi.OTG_ADDR = a; hpi.OTG_CS_N = 1'b0; hpi.OTG_RD_N = 1'b0;
        @(posedge clk);
        @(negedge clk);
        got  = otg_data;
        want = exp_q.pop_front();
        check("rd_data", got, want);
        repeat (hold - 1) @(posedge clk);
        #1;
        hpi.OTG_CS_N = 1'b1; hpi.OTG_RD_N = 1'b1;
        #2;
        check("rd_hold_after_strobe", otg_data, want);
        @(posedge clk);
        @(negedge clk);
        check("rd_release", otg_data, REL);
        $display("host rd reg=%0d data=0x%04h exp=0x%04h hold=%0d", a, got, want, hold);
    endtask

    task automatic lcl_read(input logic [MEM_AW-1:0] a, input logic [15:0] exp);
        @(posedge clk); #1;
        lcl_mem_addr = a;
        @(posedge clk);
        @(negedge clk);
        check("lcl_mem_rdata", lcl_mem_rdata, exp);
        $display("lcl rd addr=0x%03h data=0x%04h", a, lcl_mem_rdata);
    endtask

    task automatic lcl_write(input logic [15:0] d);
        @(posedge clk); #1;
        lcl_mbx_wr = 1'b1; lcl_mbx_wdata = d;
        @(posedge clk); #1;
        lcl_mbx_wr = 1'b0;
        $display("lcl mbx wr data=0x%04h", d);
    endtask

    task automatic lcl_ack();
        @(posedge clk); #1;
        lcl_mbx_ack = 1'b1;
        @(posedge clk); #1;
        lcl_mbx_ack = 1'b0;
        $display("lcl mbx ack");
    endtask

    task automatic check_rst_outputs();
        check("rst_bus", otg_data, REL);
        check("rst_int", {15'b0, hpi.OTG_INT}, 16'h0000);
        check("rst_mbx_valid", {15'b0, lcl_mbx_valid}, 16'h0000);
        check("rst_mbx_rdata", lcl_mbx_rdata, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Memory / pointer vectors: {wr, reg, data-or-expected, hold}
        tbl.push_back('{1'b1, 2'd2, 16'h0100, 1});
        tbl.push_back('{1'b1, 2'd0, 16'hAAAA, 2});
        tbl.push_back('{1'b1, 2'd0, 16'h5555, 2});
        tbl.push_back('{1'b0, 2'd2, 16'h0104, 1});
        tbl.push_back('{1'b1, 2'd2, 16'h0100, 1});
        tbl.push_back('{1'b0, 2'd0, 16'hAAAA, 1});
        tbl.push_back('{1'b0, 2'd0, 16'h5555, 2});
        tbl.push_back('{1'b0, 2'd2, 16'h0104, 1});
        tbl.push_back('{1'b1, 2'd2, 16'h0100, 1});
        tbl.push_back('{1'b0, 2'd0, 16'hAAAA, 5});
        tbl.push_back('{1'b0, 2'd2, 16'h0102, 1});
        tbl.push_back('{1'b1, 2'd2, 16'h2100, 1});   // aliases word 0x80
        tbl.push_back('{1'b0, 2'd0, 16'hAAAA, 1});
        tbl.push_back('{1'b0, 2'd2, 16'h2102, 1});
        tbl.push_back('{1'b1, 2'd2, 16'hFFFE, 1});
        tbl.push_back('{1'b1, 2'd0, 16'h0F0F, 1});
        tbl.push_back('{1'b0, 2'd2, 16'h0000, 1});

        reset = 1'b1; otg_rst_n = 1'b1;
        hpi.OTG_ADDR = 2'd0; hpi.OTG_CS_N = 1'b1; hpi.OTG_RD_N = 1'b1; hpi.OTG_WR_N = 1'b1;
        tb_drv_en = 1'b0; tb_drv = 16'h0000;
        lcl_mbx_ack = 1'b0; lcl_mbx_wr = 1'b0; lcl_mbx_wdata = 16'h0000; lcl_mem_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_rst_outputs();
        check("rst_lcl_mem_rdata", lcl_mem_rdata, 16'h0000);
        host_read(2'd3, 16'h0000, 1);
        host_read(2'd2, 16'h0000, 1);

        foreach (tbl[i]) begin
            if (tbl[i].wr) host_write(tbl[i].a, tbl[i].d, tbl[i].hold);
            else           host_read(tbl[i].a, tbl[i].d, tbl[i].hold);
        end
        lcl_read(12'h081, 16'h5555);
        lcl_read(12'h080, 16'hAAAA);
        lcl_read(12'hFFF, 16'h0F0F);

        // Chip select high: strobes toggle, nothing happens, bus stays released.
        @(posedge clk); #1;
        hpi.OTG_ADDR = 2'd2;
        for (int i = 0; i < 6; i++) begin
            hpi.OTG_WR_N = i[0];
            hpi.OTG_RD_N = ~i[0];
            @(negedge clk);
            check("cs_high_bus", otg_data, REL);
            @(posedge clk); #1;
        end
        hpi.OTG_WR_N = 1'b1; hpi.OTG_RD_N = 1'b1;
        host_read(2'd2, 16'h0000, 1);

        // Inbound mailbox, overrun, ack.
        host_write(2'd1, 16'h1234, 2);
        @(negedge clk);
        check("mbx_valid_set", {15'b0, lcl_mbx_valid}, 16'h0001);
        check("mbx_rdata", lcl_mbx_rdata, 16'h1234);
        host_write(2'd1, 16'h5678, 1);
        host_read(2'd3, 16'h0005, 1);
        host_read(2'd3, 16'h0001, 1);
        check("mbx_rdata2", lcl_mbx_rdata, 16'h5678);
        lcl_ack();
        @(negedge clk);
        check("mbx_valid_ack", {15'b0, lcl_mbx_valid}, 16'h0000);
        host_read(2'd3, 16'h0000, 1);

        // Outbound mailbox and interrupt.
        lcl_write(16'hBEEF);
        @(negedge clk);
        check("int_set", {15'b0, hpi.OTG_INT}, 16'h0001);
        host_read(2'd1, 16'hBEEF, 1);
        check("int_clr", {15'b0, hpi.OTG_INT}, 16'h0000);

        // Local write in the same cycle as the host read start.
        @(posedge clk); #1;
        hpi.OTG_ADDR = 2'd1; hpi.OTG_CS_N = 1'b0; hpi.OTG_RD_N = 1'b0;
        lcl_mbx_wr = 1'b1; lcl_mbx_wdata = 16'hCAFE;
        @(posedge clk); #1;
        lcl_mbx_wr = 1'b0;
        @(negedge clk);
        check("race_rd_old", otg_data, 16'hBEEF);
        check("race_int_kept", {15'b0, hpi.OTG_INT}, 16'h0001);
        #1 hpi.OTG_CS_N = 1'b1; hpi.OTG_RD_N = 1'b1;
        $display("race mbx rd with lcl wr 0xCAFE");
        host_read(2'd1, 16'hCAFE, 1);
        check("int_clr2", {15'b0, hpi.OTG_INT}, 16'h0000);

        // Reset in the middle of a read.
        host_write(2'd1, 16'h4321, 1);
        lcl_write(16'h7777);
        host_write(2'd2, 16'h0100, 1);
        @(posedge clk); #1;
        hpi.OTG_ADDR = 2'd0; hpi.OTG_CS_N = 1'b0; hpi.OTG_RD_N = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrd_driven", otg_data, 16'hAAAA);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; hpi.OTG_CS_N = 1'b1; hpi.OTG_RD_N = 1'b1;
        @(negedge clk);
        check_rst_outputs();
        check("midrd_lcl_mem_rdata", lcl_mem_rdata, 16'h0000);
        $display("reset during read");
        host_read(2'd3, 16'h0000, 1);
        host_read(2'd2, 16'h0000, 1);
        host_read(2'd1, 16'h0000, 1);
        host_write(2'd2, 16'h0100, 1);
        host_read(2'd0, 16'hAAAA, 1);

        // One-cycle host reset pulse.
        host_write(2'd1, 16'h1111, 1);
        lcl_write(16'h2222);
        host_write(2'd2, 16'h0200, 1);
        @(posedge clk); #1 otg_rst_n = 1'b0;
        @(posedge clk); #1 otg_rst_n = 1'b1;
        @(negedge clk);
        check_rst_outputs();
        $display("host reset pulse");
        host_read(2'd2, 16'h0000, 1);
        host_read(2'd3, 16'h0000, 1);
        lcl_read(12'h081, 16'h5555);

        check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
